uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default parameters and the divisor helper.
package uart_pkg;

   localparam int unsigned DEF_BAUD_RATE  = 9600;
   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_CLK_FREQ   = 100_000_000;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      STOP       = 3'd3,
      BREAK_WAIT = 3'd4
   } state_t;

   // Clock cycles per tick; a zero quotient is clamped to 1 (tick every clk).
   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned rate);
      int unsigned q;
      q = (rate == 0) ? 0 : clk_freq / rate;
      return (q == 0) ? 1 : q;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clk tick at RATE ticks per second.
module uart_baud_tick import uart_pkg::*; #(
   parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
   parameter int unsigned RATE     = DEF_BAUD_RATE * 16
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, RATE);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_tick;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(DIV - 1));
   assign o_tick = r_tick;

   // Counter wraps at DIV-1 and flags the wrap as a registered tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
         r_tick <= w_wrap;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start detect, mid-bit data sampling, stop check.
module uart_rx import uart_pkg::*; #(
   parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_rx,
   output logic [DATA_WIDTH-1:0] o_rxdata,
   output logic                  o_rx_valid,
   output logic                  o_frame_err,
   output logic                  o_busy
);

   localparam int unsigned SCW = $clog2(OVERSAMPLE);
   localparam int unsigned BCW = $clog2(DATA_WIDTH) + 1;

   logic                  w_tick;
   logic [1:0]            r_sync;
   logic                  w_rx_s;

   state_t                r_state,      w_state_nxt;
   logic [SCW-1:0]        r_sample_cnt, w_sample_nxt;
   logic [BCW-1:0]        r_bit_cnt,    w_bit_nxt;
   logic [DATA_WIDTH-1:0] r_shift,      w_shift_nxt;
   logic [DATA_WIDTH-1:0] r_rxdata,     w_rxdata_nxt;
   logic                  r_valid,      w_valid_nxt;
   logic                  r_err,        w_err_nxt;
   logic                  r_busy,       w_busy_nxt;

   uart_baud_tick #(
      .CLK_FREQ (CLK_FREQ),
      .RATE     (BAUD_RATE * OVERSAMPLE)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .o_tick (w_tick)
   );

   assign w_rx_s      = r_sync[1];
   assign o_rxdata    = r_rxdata;
   assign o_rx_valid  = r_valid;
   assign o_frame_err = r_err;
   assign o_busy      = r_busy;

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk) begin
      if (rst) r_sync <= 2'b11;
      else     r_sync <= {r_sync[0], i_rx};
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_sample_cnt <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_rxdata     <= '0;
         r_valid      <= 1'b0;
         r_err        <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sample_cnt <= w_sample_nxt;
         r_bit_cnt    <= w_bit_nxt;
         r_shift      <= w_shift_nxt;
         r_rxdata     <= w_rxdata_nxt;
         r_valid      <= w_valid_nxt;
         r_err        <= w_err_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   // Next-state and output decode; pulses default low, everything else holds.
   always_comb begin
      w_state_nxt  = r_state;
      w_sample_nxt = r_sample_cnt;
      w_bit_nxt    = r_bit_cnt;
      w_shift_nxt  = r_shift;
      w_rxdata_nxt = r_rxdata;
      w_valid_nxt  = 1'b0;
      w_err_nxt    = 1'b0;
      w_busy_nxt   = r_busy;

      case (r_state)
         IDLE: begin
            if (w_tick && !w_rx_s) begin
               w_state_nxt  = START;
               w_sample_nxt = '0;
               w_busy_nxt   = 1'b1;
            end
         end
         START: begin
            if (w_tick) begin
               if (r_sample_cnt == SCW'(OVERSAMPLE / 2 - 1)) begin
                  if (!w_rx_s) begin
                     w_state_nxt  = DATA;
                     w_sample_nxt = '0;
                     w_bit_nxt    = '0;
                  end else begin
                     w_state_nxt = IDLE;
                     w_busy_nxt  = 1'b0;
                  end
               end else begin
                  w_sample_nxt = r_sample_cnt + SCW'(1);
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_sample_cnt == SCW'(OVERSAMPLE - 1)) begin
                  w_sample_nxt = '0;
                  w_shift_nxt  = {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                  if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                     w_state_nxt = STOP;
                     w_bit_nxt   = '0;
                  end else begin
                     w_bit_nxt = r_bit_cnt + BCW'(1);
                  end
               end else begin
                  w_sample_nxt = r_sample_cnt + SCW'(1);
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_sample_cnt == SCW'(OVERSAMPLE - 1)) begin
                  w_sample_nxt = '0;
                  if (w_rx_s) begin
                     w_rxdata_nxt = r_shift;
                     w_valid_nxt  = 1'b1;
                     w_busy_nxt   = 1'b0;
                     w_state_nxt  = IDLE;
                  end else begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = BREAK_WAIT;
                  end
               end else begin
                  w_sample_nxt = r_sample_cnt + SCW'(1);
               end
            end
         end
         BREAK_WAIT: begin
            // Checked every clk so a long break yields a single error.
            if (w_rx_s) begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 32 clk per bit.
module tb_uart_rx;

   localparam int unsigned DW  = 8;
   localparam int          BIT = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_rx = 1'b1;
   logic [DW-1:0] o_rxdata;
   logic          o_rx_valid;
   logic          o_frame_err;
   logic          o_busy;

   int n_cmp = 0;
   int n_bad = 0;

   int            valid_cnt = 0;
   int            err_cnt   = 0;
   int            excl_viol = 0;
   int            long_viol = 0;
   logic          prev_v = 1'b0;
   logic          prev_e = 1'b0;
   logic [DW-1:0] data_q[$];

   uart_rx #(
      .BAUD_RATE  (100_000),
      .DATA_WIDTH (DW),
      .CLK_FREQ   (3_200_000),
      .OVERSAMPLE (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx        (i_rx),
      .o_rxdata    (o_rxdata),
      .o_rx_valid  (o_rx_valid),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   // Pulse recorder, sampled on the inactive edge.
   always @(negedge clk) begin
      if (o_rx_valid) begin
         valid_cnt++;
         data_q.push_back(o_rxdata);
      end
      if (o_frame_err) err_cnt++;
      if (o_rx_valid && o_frame_err) excl_viol++;
      if ((o_rx_valid && prev_v) || (o_frame_err && prev_e)) long_viol++;
      prev_v = o_rx_valid;
      prev_e = o_frame_err;
   end

   task automatic drive(input logic v, input int n);
      i_rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop);
      drive(1'b0, BIT);
      for (int i = 0; i < DW; i++) drive(d[i], BIT);
      drive(stop, BIT);
   endtask

   task automatic clear_counts();
      valid_cnt = 0;
      err_cnt   = 0;
      data_q.delete();
   endtask

   task automatic chk_counts(input string name, input int exp_v, input int exp_e);
      n_cmp++;
      if (valid_cnt !== exp_v) begin
         n_bad++;
         $display("FAIL %s valid_count got %0d exp %0d", name, valid_cnt, exp_v);
      end
      n_cmp++;
      if (err_cnt !== exp_e) begin
         n_bad++;
         $display("FAIL %s err_count got %0d exp %0d", name, err_cnt, exp_e);
      end
   endtask

   task automatic chk_word(input string name, input logic [DW-1:0] exp);
      logic [DW-1:0] got;
      n_cmp++;
      if (data_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s word got none exp %02h", name, exp);
      end else begin
         got = data_q.pop_front();
         if (got !== exp) begin
            n_bad++;
            $display("FAIL %s word got %02h exp %02h", name, got, exp);
         end
      end
   endtask

   task automatic chk_outs(input string name, input logic [DW-1:0] exp_d,
                           input logic exp_busy);
      n_cmp++;
      if (o_rxdata !== exp_d) begin
         n_bad++;
         $display("FAIL %s o_rxdata got %02h exp %02h", name, o_rxdata, exp_d);
      end
      n_cmp++;
      if (o_busy !== exp_busy) begin
         n_bad++;
         $display("FAIL %s o_busy got %b exp %b", name, o_busy, exp_busy);
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      i_rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk_outs("reset", 8'h00, 1'b0);
      n_cmp++;
      if (o_rx_valid !== 1'b0 || o_frame_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset pulses got v=%b e=%b exp 0 0", o_rx_valid, o_frame_err);
      end
      rst = 1'b0;
      drive(1'b1, 2 * BIT);
      clear_counts();
   endtask

   task automatic test_single();
      clear_counts();
      send_frame(8'hA5, 1'b1);
      drive(1'b1, BIT);
      chk_counts("single", 1, 0);
      chk_word("single", 8'hA5);
      chk_outs("single", 8'hA5, 1'b0);
   endtask

   task automatic test_back_to_back();
      clear_counts();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h3C, 1'b1);
      drive(1'b1, BIT);
      chk_counts("b2b", 3, 0);
      chk_word("b2b_0", 8'h00);
      chk_word("b2b_1", 8'hFF);
      chk_word("b2b_2", 8'h3C);
   endtask

   task automatic test_frame_err();
      clear_counts();
      drive(1'b0, BIT);
      for (int i = 0; i < DW; i++) drive(((8'h55 >> i) & 8'h01) != 0, BIT);
      drive(1'b0, 3 * BIT);
      drive(1'b1, 2 * BIT);
      chk_counts("ferr", 0, 1);
      chk_outs("ferr", 8'h3C, 1'b0);
      clear_counts();
      send_frame(8'h81, 1'b1);
      drive(1'b1, BIT);
      chk_counts("after_ferr", 1, 0);
      chk_word("after_ferr", 8'h81);
   endtask

   task automatic test_glitch();
      clear_counts();
      drive(1'b0, 8);
      drive(1'b1, BIT - 8);
      chk_counts("glitch", 0, 0);
      chk_outs("glitch", 8'h81, 1'b0);
      drive(1'b1, BIT);
      send_frame(8'h7E, 1'b1);
      drive(1'b1, BIT);
      chk_counts("after_glitch", 1, 0);
      chk_word("after_glitch", 8'h7E);
   endtask

   task automatic test_reset_mid_frame();
      clear_counts();
      drive(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive(((8'hC3 >> i) & 8'h01) != 0, BIT);
      drive(1'b0, BIT / 2);
      n_cmp++;
      if (o_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst busy_before got %b exp 1", o_busy);
      end
      rst  = 1'b1;
      i_rx = 1'b1;
      @(posedge clk);
      #1;
      chk_outs("midrst", 8'h00, 1'b0);
      n_cmp++;
      if (o_rx_valid !== 1'b0 || o_frame_err !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst pulses got v=%b e=%b exp 0 0", o_rx_valid, o_frame_err);
      end
      rst = 1'b0;
      drive(1'b1, 2 * BIT);
      chk_counts("midrst_quiet", 0, 0);
      send_frame(8'h12, 1'b1);
      drive(1'b1, BIT);
      chk_counts("after_midrst", 1, 0);
      chk_word("after_midrst", 8'h12);
   endtask

   task automatic test_break();
      clear_counts();
      drive(1'b0, 20 * BIT);
      drive(1'b1, 2 * BIT);
      chk_counts("break", 0, 1);
      chk_outs("break", 8'h12, 1'b0);
   endtask

   task automatic test_pulse_shape();
      n_cmp++;
      if (excl_viol !== 0) begin
         n_bad++;
         $display("FAIL pulse_excl got %0d exp 0", excl_viol);
      end
      n_cmp++;
      if (long_viol !== 0) begin
         n_bad++;
         $display("FAIL pulse_width got %0d exp 0", long_viol);
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_reset_mid_frame();
      test_break();
      test_pulse_shape();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
